// File: rtl/dmem_ctrl.sv
// MIPS data memory with request/response handshake, byte/half/word lanes,
// sign/zero extension, 1- or 2-cycle read latency, fault capture and access counters.
module dmem_ctrl #(
   parameter int    ADDR_W    = 12,
   parameter int    RD_LAT    = 1,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_uns,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              fault,
   output logic [ADDR_W-1:0] fault_addr,
   input  logic              fault_clr,
   output logic [15:0]       stat_rd,
   output logic [15:0]       stat_wr
);

   localparam int DEPTH = 2**(ADDR_W-2);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [31:0] mem [DEPTH];

   logic              accept;
   logic              bad;
   logic              st_fire;
   logic              ld_fire;
   logic              ld_ok;
   logic [ADDR_W-3:0] idx;
   logic [3:0]        be;
   logic [31:0]       wdat;
   logic [31:0]       rd_word;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       ld_data;
   logic              out_v;
   logic              out_ok;
   logic [31:0]       out_d;

   assign accept  = req_valid & req_ready;
   assign idx     = req_addr[ADDR_W-1:2];
   assign bad     = (req_size == 2'b11) ||
                    (req_size == SZ_HALF && req_addr[0]) ||
                    (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
   assign st_fire = accept & req_we & ~bad;
   assign ld_fire = accept & ~req_we;
   assign ld_ok   = ~bad;

   // Big-endian lanes: lane 3 holds bits [31:24] and is the byte at offset 0.
   always_comb begin
      be   = 4'b0000;
      wdat = req_wdata;
      case (req_size)
         SZ_BYTE: begin
            be   = 4'b1000 >> req_addr[1:0];
            wdat = {4{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            be   = req_addr[1] ? 4'b0011 : 4'b1100;
            wdat = {2{req_wdata[15:0]}};
         end
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   // NOTE: the array has no reset branch; resetting it would turn the RAM into flops.
   always_ff @(posedge clk) begin
      if (st_fire) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
         end
      end
   end

   assign rd_word = mem[idx];

   always_comb begin
      case (req_addr[1:0])
         2'd0:    rd_byte = rd_word[31:24];
         2'd1:    rd_byte = rd_word[23:16];
         2'd2:    rd_byte = rd_word[15:8];
         default: rd_byte = rd_word[7:0];
      endcase
      rd_half = req_addr[1] ? rd_word[15:0] : rd_word[31:16];
   end

   // Faulting loads still respond, but with zero data.
   always_comb begin
      ld_data = 32'd0;
      if (ld_ok) begin
         case (req_size)
            SZ_BYTE: ld_data = req_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: ld_data = req_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            SZ_WORD: ld_data = rd_word;
            default: ld_data = 32'd0;
         endcase
      end
   end

   // Any RD_LAT other than 2 builds the single-cycle path.
   if (RD_LAT == 2) begin : g_lat2
      logic        s1_v;
      logic        s1_ok;
      logic [31:0] s1_d;

      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s1_v  <= 1'b0;
            s1_ok <= 1'b0;
            s1_d  <= 32'd0;
         end else begin
            s1_v  <= ld_fire;
            s1_ok <= ld_ok;
            if (ld_fire) s1_d <= ld_data;
         end
      end

      assign out_v  = s1_v;
      assign out_ok = s1_ok;
      assign out_d  = s1_d;
   end else begin : g_lat1
      assign out_v  = ld_fire;
      assign out_ok = ld_ok;
      assign out_d  = ld_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
      end else begin
         req_ready  <= 1'b1;
         resp_valid <= out_v;
         if (out_v) resp_rdata <= out_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_rd <= 16'd0;
         stat_wr <= 16'd0;
      end else begin
         if (out_v && out_ok && stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
         if (st_fire && stat_wr != 16'hFFFF)         stat_wr <= stat_wr + 16'd1;
      end
   end

   // A new fault outranks a simultaneous clear; otherwise the first fault address is kept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end else if (accept && bad) begin
         fault <= 1'b1;
         if (!fault || fault_clr) fault_addr <= req_addr;
      end else if (fault_clr) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: RD_LAT=1 and RD_LAT=2 instances share stimulus,
// each with its own response scoreboard that checks data and arrival cycle.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_uns;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        fault_clr;

   logic        ready1, rv1, fault1;
   logic [31:0] rd1;
   logic [11:0] fa1;
   logic [15:0] srd1, swr1;
   logic        ready2, rv2, fault2;
   logic [31:0] rd2;
   logic [11:0] fa2;
   logic [15:0] srd2, swr2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[14];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_ctrl #(.ADDR_W(12), .RD_LAT(1), .INIT_FILE("")) u_lat1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
      .req_we(req_we), .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1), .fault(fault1),
      .fault_addr(fa1), .fault_clr(fault_clr), .stat_rd(srd1), .stat_wr(swr1)
   );

   dmem_ctrl #(.ADDR_W(12), .RD_LAT(2), .INIT_FILE("")) u_lat2 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2),
      .req_we(req_we), .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(rv2), .resp_rdata(rd2), .fault(fault2),
      .fault_addr(fa2), .fault_clr(fault_clr), .stat_rd(srd2), .stat_wr(swr2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drives one request for exactly one accept edge; loads optionally push expectations.
   task automatic op(input logic we, input logic [1:0] size, input logic uns,
                     input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp, input bit push);
      exp_t e;
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_uns   = uns;
      req_addr  = addr;
      req_wdata = wdata;
      if (!we && push) begin
         e.data = exp; e.due = cyc + 1; q1.push_back(e);
         e.data = exp; e.due = cyc + 2; q2.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_stats(input string tag, input logic [15:0] rd, input logic [15:0] wr);
      check({tag, " lat1 stat_rd"}, {16'd0, srd1}, {16'd0, rd});
      check({tag, " lat1 stat_wr"}, {16'd0, swr1}, {16'd0, wr});
      check({tag, " lat2 stat_rd"}, {16'd0, srd2}, {16'd0, rd});
      check({tag, " lat2 stat_wr"}, {16'd0, swr2}, {16'd0, wr});
   endtask

   task automatic check_fault(input string tag, input logic f, input logic [11:0] a);
      check({tag, " lat1 fault"},      {31'd0, fault1}, {31'd0, f});
      check({tag, " lat1 fault_addr"}, {20'd0, fa1},    {20'd0, a});
      check({tag, " lat2 fault"},      {31'd0, fault2}, {31'd0, f});
      check({tag, " lat2 fault_addr"}, {20'd0, fa2},    {20'd0, a});
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " lat1 ready"},  {31'd0, ready1}, 32'd0);
      check({tag, " lat2 ready"},  {31'd0, ready2}, 32'd0);
      check({tag, " lat1 rvalid"}, {31'd0, rv1},    32'd0);
      check({tag, " lat2 rvalid"}, {31'd0, rv2},    32'd0);
      check({tag, " lat1 rdata"},  rd1,             32'd0);
      check({tag, " lat2 rdata"},  rd2,             32'd0);
      check_fault(tag, 1'b0, 12'h000);
      check_stats(tag, 16'd0, 16'd0);
   endtask

   always @(negedge clk) begin
      if (rv1) begin
         if (q1.size() == 0) check("lat1 spurious resp", {31'd0, rv1}, 32'd0);
         else begin
            exp_t e;
            e = q1.pop_front();
            check("lat1 rdata", rd1, e.data);
            check("lat1 resp cycle", 32'(cyc), 32'(e.due));
         end
      end
      if (rv2) begin
         if (q2.size() == 0) check("lat2 spurious resp", {31'd0, rv2}, 32'd0);
         else begin
            exp_t e;
            e = q2.pop_front();
            check("lat2 rdata", rd2, e.data);
            check("lat2 resp cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          we    size   uns   addr     wdata          expected
      tbl[0]  = '{1'b1, 2'd2, 1'b0, 12'h010, 32'h80FF7F01, 32'h0};
      tbl[1]  = '{1'b0, 2'd0, 1'b0, 12'h010, 32'h0,        32'hFFFFFF80};
      tbl[2]  = '{1'b0, 2'd0, 1'b1, 12'h011, 32'h0,        32'h000000FF};
      tbl[3]  = '{1'b0, 2'd1, 1'b0, 12'h012, 32'h0,        32'h00007F01};
      tbl[4]  = '{1'b0, 2'd1, 1'b1, 12'h010, 32'h0,        32'h000080FF};
      tbl[5]  = '{1'b0, 2'd1, 1'b0, 12'h010, 32'h0,        32'hFFFF80FF};
      tbl[6]  = '{1'b1, 2'd0, 1'b0, 12'h013, 32'hFFFFFF5A, 32'h0};
      tbl[7]  = '{1'b1, 2'd1, 1'b0, 12'h010, 32'hAAAA1234, 32'h0};
      tbl[8]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        32'h12347F5A};
      tbl[9]  = '{1'b1, 2'd2, 1'b0, 12'h024, 32'hDEADBEEF, 32'h0};
      tbl[10] = '{1'b0, 2'd0, 1'b0, 12'h027, 32'h0,        32'hFFFFFFEF};
      tbl[11] = '{1'b0, 2'd0, 1'b1, 12'h025, 32'h0,        32'h000000AD};
      tbl[12] = '{1'b0, 2'd1, 1'b0, 12'h026, 32'h0,        32'hFFFFBEEF};
      tbl[13] = '{1'b0, 2'd2, 1'b0, 12'h024, 32'h0,        32'hDEADBEEF};

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_uns = 1'b0; req_addr = 12'h0; req_wdata = 32'h0; fault_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("por");
      reset = 1'b0;
      @(posedge clk); #1;
      check("lat1 ready after reset", {31'd0, ready1}, 32'd1);
      check("lat2 ready after reset", {31'd0, ready2}, 32'd1);

      // Back-to-back table: includes load-after-store and 4+ consecutive loads.
      for (int i = 0; i < 14; i++)
         op(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b1);
      idle(4);
      check_stats("table", 16'd10, 16'd4);
      check_fault("table", 1'b0, 12'h000);

      // Faults: first address kept, faulting store leaves memory alone.
      op(1'b1, 2'd2, 1'b0, 12'h000, 32'h11223344, 32'h0, 1'b0);
      op(1'b0, 2'd2, 1'b0, 12'h006, 32'h0, 32'h0, 1'b1);
      check_fault("lw misaligned", 1'b1, 12'h006);
      op(1'b1, 2'd1, 1'b0, 12'h003, 32'h0000FFFF, 32'h0, 1'b0);
      check_fault("sh misaligned", 1'b1, 12'h006);
      op(1'b0, 2'd2, 1'b0, 12'h000, 32'h0, 32'h11223344, 1'b1);
      idle(4);
      check_stats("fault", 16'd11, 16'd5);
      fault_clr = 1'b1;
      idle(1);
      fault_clr = 1'b0;
      check_fault("clear", 1'b0, 12'h000);

      // Clear coinciding with a new fault (illegal size): new fault wins.
      op(1'b0, 2'd3, 1'b0, 12'h040, 32'h0, 32'h0, 1'b1);
      check_fault("size3", 1'b1, 12'h040);
      fault_clr = 1'b1;
      op(1'b0, 2'd3, 1'b1, 12'h044, 32'h0, 32'h0, 1'b1);
      fault_clr = 1'b0;
      check_fault("clr+fault", 1'b1, 12'h044);
      idle(4);
      check_stats("size3", 16'd11, 16'd5);

      // Reset right after a load accept: no response, store survives.
      op(1'b1, 2'd2, 1'b0, 12'h030, 32'hCAFEF00D, 32'h0, 1'b0);
      op(1'b0, 2'd2, 1'b0, 12'h030, 32'h0, 32'h0, 1'b0);
      reset = 1'b1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("mid-op reset");
      reset = 1'b0;
      #1;
      check("lat1 ready before edge", {31'd0, ready1}, 32'd0);
      check("lat2 ready before edge", {31'd0, ready2}, 32'd0);
      @(posedge clk); #1;
      check("lat1 ready after edge", {31'd0, ready1}, 32'd1);
      check("lat2 ready after edge", {31'd0, ready2}, 32'd1);
      op(1'b0, 2'd2, 1'b0, 12'h030, 32'h0, 32'hCAFEF00D, 1'b1);
      op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'h12347F5A, 1'b1);
      idle(4);
      check_stats("post reset", 16'd2, 16'd0);

      check("lat1 queue drained", 32'(q1.size()), 32'd0);
      check("lat2 queue drained", 32'(q2.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
